// File: rtl/morra_pkg.sv
// Shared types and constants for the morra-cinese match driver.
// Optional build macro: INVALID_MOVE_EN (invalid-move injection on player 1).
package morra_pkg;

    // Move encoding on the game interface
    typedef enum logic [1:0] {
        MOVE_NONE    = 2'b00,
        MOVE_SASSO   = 2'b01,
        MOVE_CARTA   = 2'b10,
        MOVE_FORBICE = 2'b11
    } move_t;

    // Result encoding shared by manche and partita (00 = none / ongoing)
    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_G1   = 2'b01,
        RES_G2   = 2'b10,
        RES_TIE  = 2'b11
    } result_t;

    // Driver sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_PLAY,
        ST_TALLY,
        ST_FINISH
    } state_t;

    // The game adds this offset to the 4-bit config code to get the manche limit
    localparam int MANCHE_MAX_OFS = 4;

    // Manche limit implied by a config code
    function automatic int manche_max(input logic [3:0] code);
        return int'(code) + MANCHE_MAX_OFS;
    endfunction

    // Map two LFSR bits onto a legal move: 00 would be invalid, so fold it onto sasso
    function automatic move_t bits_to_move(input logic [1:0] bits);
        return (bits == 2'b00) ? MOVE_SASSO : move_t'(bits);
    endfunction

endpackage

// File: rtl/morra_match_driver_if.sv
// Player-side bus between the match driver (master) and the morra game (slave).
interface morra_match_driver_if;
    import morra_pkg::*;

    logic    game_reset;
    move_t   g1;
    move_t   g2;
    result_t manche;
    result_t partita;

    modport master (
        output game_reset, g1, g2,
        input  manche, partita
    );

    modport slave (
        input  game_reset, g1, g2,
        output manche, partita
    );
endinterface

// File: rtl/morra_lfsr_move.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11, shift left) producing one move per step.
// With INVALID_MOVE_EN defined, an instance built with INJECT=1 emits MOVE_NONE
// whenever LFSR[7:4]==4'hF; otherwise the injection logic does not exist.
module morra_lfsr_move
    import morra_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
`ifdef INVALID_MOVE_EN
    ,
    parameter bit INJECT = 1'b0
`endif
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  step,
    output move_t move
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    // Next LFSR value: advance only when asked, XNOR-free so the seed must be nonzero
    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = lfsr_q;
        if (step) begin
            lfsr_d = {lfsr_q[14:0], feedback};
        end
    end

    // LFSR state register, reloaded with the seed on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Move decode from the low bits, with optional invalid-move injection
    always_comb begin
        move = bits_to_move(lfsr_q[1:0]);
`ifdef INVALID_MOVE_EN
        if (INJECT && (lfsr_q[7:4] == 4'hF)) begin
            move = MOVE_NONE;
        end
`endif
    end

endmodule

// File: rtl/morra_match_driver.sv
// Player-side traffic source for the morra-cinese game: configures the game,
// streams LFSR move pairs, tallies match results over a run of matches and
// flags matches that never conclude within TIMEOUT PLAY cycles.
// Optional build macro: INVALID_MOVE_EN (player 1 occasionally plays 00).
module morra_match_driver
    import morra_pkg::*;
#(
    parameter logic [15:0] SEED1   = 16'hACE1,
    parameter logic [15:0] SEED2   = 16'h1D0F,
    parameter logic [7:0]  TIMEOUT = 8'd64,
    parameter int          CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_matches,
    input  logic [3:0]           cfg_max,
    morra_match_driver_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     wins_g1,
    output logic [CNT_W-1:0]     wins_g2,
    output logic [CNT_W-1:0]     draws,
    output logic                 timeout_err
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q,       state_d;
    logic [7:0]       cnt_q,         cnt_d;
    logic [CNT_W-1:0] remaining_q,   remaining_d;
    logic [3:0]       cfg_q,         cfg_d;
    result_t          result_q,      result_d;
    logic [CNT_W-1:0] wins_g1_q,     wins_g1_d;
    logic [CNT_W-1:0] wins_g2_q,     wins_g2_d;
    logic [CNT_W-1:0] draws_q,       draws_d;
    logic             timeout_err_q, timeout_err_d;
    logic             zero_done_q,   zero_done_d;

    move_t move1;
    move_t move2;
    logic  lfsr_step;

    assign lfsr_step = (state_q == ST_PLAY);

    morra_lfsr_move #(
        .SEED   (SEED1)
`ifdef INVALID_MOVE_EN
        ,
        .INJECT (1'b1)
`endif
    ) u_lfsr1 (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step),
        .move  (move1)
    );

    morra_lfsr_move #(
        .SEED   (SEED2)
`ifdef INVALID_MOVE_EN
        ,
        .INJECT (1'b0)
`endif
    ) u_lfsr2 (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step),
        .move  (move2)
    );

    // Next-state logic: sequencing, timeout counting and saturating tallies
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        remaining_d   = remaining_q;
        cfg_d         = cfg_q;
        result_d      = result_q;
        wins_g1_d     = wins_g1_q;
        wins_g2_d     = wins_g2_q;
        draws_d       = draws_q;
        timeout_err_d = timeout_err_q;
        zero_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    wins_g1_d     = '0;
                    wins_g2_d     = '0;
                    draws_d       = '0;
                    timeout_err_d = 1'b0;
                    remaining_d   = num_matches;
                    cfg_d         = cfg_max;
                    // An empty run never leaves IDLE but still reports completion
                    if (num_matches == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d = ST_CONFIG;
                    end
                end
            end
            ST_CONFIG: begin
                cnt_d   = '0;
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                cnt_d = cnt_q + 8'd1;
                // A concluded match wins over a coincident timeout
                if (bus.partita != RES_NONE) begin
                    result_d = bus.partita;
                    state_d  = ST_TALLY;
                end else if (cnt_q == (TIMEOUT - 8'd1)) begin
                    result_d      = RES_NONE;
                    timeout_err_d = 1'b1;
                    state_d       = ST_TALLY;
                end
            end
            ST_TALLY: begin
                case (result_q)
                    RES_G1:  if (wins_g1_q != '1) wins_g1_d = wins_g1_q + CNT_ONE;
                    RES_G2:  if (wins_g2_q != '1) wins_g2_d = wins_g2_q + CNT_ONE;
                    RES_TIE: if (draws_q   != '1) draws_d   = draws_q   + CNT_ONE;
                    default: ;
                endcase
                remaining_d = remaining_q - CNT_ONE;
                state_d     = (remaining_q > CNT_ONE) ? ST_CONFIG : ST_FINISH;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Game-side and status outputs decoded from the current state
    always_comb begin
        bus.game_reset = 1'b1;
        bus.g1         = MOVE_NONE;
        bus.g2         = MOVE_NONE;
        busy           = 1'b1;
        done           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                done = zero_done_q;
            end
            ST_CONFIG: begin
                bus.g1 = move_t'(cfg_q[3:2]);
                bus.g2 = move_t'(cfg_q[1:0]);
            end
            ST_PLAY: begin
                bus.game_reset = 1'b0;
                bus.g1         = move1;
                bus.g2         = move2;
            end
            ST_FINISH: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            remaining_q   <= '0;
            cfg_q         <= '0;
            result_q      <= RES_NONE;
            wins_g1_q     <= '0;
            wins_g2_q     <= '0;
            draws_q       <= '0;
            timeout_err_q <= 1'b0;
            zero_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            remaining_q   <= remaining_d;
            cfg_q         <= cfg_d;
            result_q      <= result_d;
            wins_g1_q     <= wins_g1_d;
            wins_g2_q     <= wins_g2_d;
            draws_q       <= draws_d;
            timeout_err_q <= timeout_err_d;
            zero_done_q   <= zero_done_d;
        end
    end

    assign wins_g1     = wins_g1_q;
    assign wins_g2     = wins_g2_q;
    assign draws       = draws_q;
    assign timeout_err = timeout_err_q;

endmodule
